mul_shift_issue: RTL and testbench



---
 rtl/mul_pkg.sv | 19 +
 rtl/mul_shift_issue.sv | 119 +++++++++++
 tb/tb_mul_shift_issue.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared types and sizing helpers for the shift-multiplier issue/capture stage.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic int defaultTimeout(input int dataWidth);
    return 2 * dataWidth + 4;
  endfunction

  localparam int DEFAULT_DATA_WIDTH = 4;
  localparam int DEFAULT_TIMEOUT    = defaultTimeout(DEFAULT_DATA_WIDTH);
  localparam int TIMEOUT_CNT_W      = $clog2(DEFAULT_TIMEOUT + 1);

endpackage

// File: rtl/mul_shift_issue.sv
// Issues latched operands to the shift multiplier, waits for its end flag
// under a watchdog, and holds the product on a valid/ready result port.
module mul_shift_issue
  import mul_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int TIMEOUT    = defaultTimeout(DATA_WIDTH)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_req_valid,
  output logic                    o_req_ready,
  input  logic [DATA_WIDTH-1:0]   i_num_x,
  input  logic [DATA_WIDTH-1:0]   i_num_y,
  output logic                    o_mul_rst_n,
  output logic [DATA_WIDTH-1:0]   o_mul_num_x,
  output logic [DATA_WIDTH-1:0]   o_mul_num_y,
  input  logic                    i_mul_end,
  input  logic [2*DATA_WIDTH-1:0] i_mul_res,
  output logic                    o_res_valid,
  input  logic                    i_res_ready,
  output logic [2*DATA_WIDTH-1:0] o_res,
  output logic                    o_res_err
);

  // Reuse the package width for the default watchdog, recompute when overridden.
  localparam int CntW = (TIMEOUT == DEFAULT_TIMEOUT) ? TIMEOUT_CNT_W : $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] LastCount = CntW'(TIMEOUT - 1);

  state_e                  state_q, state_d;
  logic [CntW-1:0]         count_q, count_d;
  logic                    mulRstN_q, mulRstN_d;
  logic [DATA_WIDTH-1:0]   numX_q, numX_d;
  logic [DATA_WIDTH-1:0]   numY_q, numY_d;
  logic                    resValid_q, resValid_d;
  logic [2*DATA_WIDTH-1:0] res_q, res_d;
  logic                    resErr_q, resErr_d;

  assign o_req_ready = (state_q == IDLE) && !i_rst;
  assign o_mul_rst_n = mulRstN_q;
  assign o_mul_num_x = numX_q;
  assign o_mul_num_y = numY_q;
  assign o_res_valid = resValid_q;
  assign o_res       = res_q;
  assign o_res_err   = resErr_q;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    mulRstN_d  = 1'b0;
    numX_d     = numX_q;
    numY_d     = numY_q;
    resValid_d = resValid_q;
    res_d      = res_q;
    resErr_d   = resErr_q;
    case (state_q)
      IDLE: begin
        if (i_req_valid && o_req_ready) begin
          numX_d  = i_num_x;
          numY_d  = i_num_y;
          state_d = LOAD;
        end
      end
      LOAD: begin
        mulRstN_d = 1'b1;
        state_d   = RUN;
      end
      RUN: begin
        mulRstN_d = 1'b1;
        count_d   = count_q + 1'b1;
        // A leftover end flag from the previous operation is visible in the first RUN cycle.
        if ((count_q != '0) && i_mul_end) begin
          res_d      = i_mul_res;
          resErr_d   = 1'b0;
          resValid_d = 1'b1;
          mulRstN_d  = 1'b0;
          state_d    = DONE;
        end else if (count_q == LastCount) begin
          res_d      = '0;
          resErr_d   = 1'b1;
          resValid_d = 1'b1;
          mulRstN_d  = 1'b0;
          state_d    = DONE;
        end
      end
      DONE: begin
        if (i_res_ready) begin
          resValid_d = 1'b0;
          count_d    = '0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      mulRstN_q  <= 1'b0;
      numX_q     <= '0;
      numY_q     <= '0;
      resValid_q <= 1'b0;
      res_q      <= '0;
      resErr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      mulRstN_q  <= mulRstN_d;
      numX_q     <= numX_d;
      numY_q     <= numY_d;
      resValid_q <= resValid_d;
      res_q      <= res_d;
      resErr_q   <= resErr_d;
    end
  end

endmodule

// File: tb/tb_mul_shift_issue.sv
// Randomized self-checking bench for mul_shift_issue with a behavioural
// stand-in for the shift multiplier (normal, stale-flag and never-ending modes).
module tb_mul_shift_issue;

  localparam int DW = 4;
  localparam int PW = 2 * DW;
  localparam int TO = 2 * DW + 4;

  localparam int MODE_NORMAL = 0;
  localparam int MODE_STALE  = 1;
  localparam int MODE_HANG   = 2;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_req_valid;
  logic          o_req_ready;
  logic [DW-1:0] i_num_x;
  logic [DW-1:0] i_num_y;
  logic          o_mul_rst_n;
  logic [DW-1:0] o_mul_num_x;
  logic [DW-1:0] o_mul_num_y;
  logic          i_mul_end;
  logic [PW-1:0] i_mul_res;
  logic          o_res_valid;
  logic          i_res_ready;
  logic [PW-1:0] o_res;
  logic          o_res_err;

  int vectors    = 0;
  int miscompares = 0;
  int mulMode    = MODE_NORMAL;
  int mulLat     = 4;
  int mulCycles  = 0;

  mul_shift_issue #(.DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_num_x     (i_num_x),
    .i_num_y     (i_num_y),
    .o_mul_rst_n (o_mul_rst_n),
    .o_mul_num_x (o_mul_num_x),
    .o_mul_num_y (o_mul_num_y),
    .i_mul_end   (i_mul_end),
    .i_mul_res   (i_mul_res),
    .o_res_valid (o_res_valid),
    .i_res_ready (i_res_ready),
    .o_res       (o_res),
    .o_res_err   (o_res_err)
  );

  always #5 i_clk = ~i_clk;

  // Multiplier stand-in: counts cycles out of reset and raises end after mulLat cycles.
  always @(posedge i_clk) begin
    if (!o_mul_rst_n) mulCycles <= 0;
    else              mulCycles <= mulCycles + 1;
  end

  always_comb begin
    i_mul_end = 1'b0;
    i_mul_res = PW'(8'hEE);
    if (o_mul_rst_n) begin
      if (mulMode == MODE_STALE && mulCycles == 0) begin
        i_mul_end = 1'b1;
      end
      if (mulMode != MODE_HANG && mulCycles >= mulLat) begin
        i_mul_end = 1'b1;
        i_mul_res = PW'(o_mul_num_x) * PW'(o_mul_num_y);
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One full operation: accept, run, optional stalled DONE, release.
  task automatic applyStimulus(input logic [DW-1:0] x, input logic [DW-1:0] y,
                               input int mode, input int lat, input int hold);
    int            waitCnt;
    int            cycles;
    int            holdBad;
    logic [PW-1:0] expRes;
    logic          expErr;
    int            expLat;
    if (mode == MODE_HANG) begin
      expRes = '0;
      expErr = 1'b1;
      expLat = TO + 1;
    end else begin
      expRes = PW'(x * y);
      expErr = 1'b0;
      expLat = lat + 2;
    end
    mulMode = mode;
    mulLat  = lat;
    waitCnt = 0;
    while (!o_req_ready && waitCnt < 20) begin
      @(negedge i_clk);
      waitCnt++;
    end
    @(negedge i_clk);
    i_req_valid = 1'b1;
    i_res_ready = 1'b0;
    i_num_x     = x;
    i_num_y     = y;
    checkOutput("reqReady", 32'(o_req_ready), 32'd1);
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    i_num_x     = DW'($urandom);
    i_num_y     = DW'($urandom);
    checkOutput("readyDrop", 32'(o_req_ready), 32'd0);
    checkOutput("loadRstN", 32'(o_mul_rst_n), 32'd0);
    checkOutput("latchX", 32'(o_mul_num_x), 32'(x));
    checkOutput("latchY", 32'(o_mul_num_y), 32'(y));
    cycles  = 0;
    holdBad = 0;
    while (!o_res_valid && cycles < TO + 8) begin
      @(negedge i_clk);
      i_num_x     = DW'($urandom);
      i_num_y     = DW'($urandom);
      i_req_valid = 1'($urandom);
      i_res_ready = 1'($urandom);
      @(posedge i_clk); #1;
      cycles++;
      if (o_mul_num_x !== x || o_mul_num_y !== y) holdBad++;
      if (cycles == 1) checkOutput("runRstN", 32'(o_mul_rst_n), 32'd1);
    end
    checkOutput("resValid", 32'(o_res_valid), 32'd1);
    checkOutput("latency", 32'(cycles), 32'(expLat));
    checkOutput("res", 32'(o_res), 32'(expRes));
    checkOutput("resErr", 32'(o_res_err), 32'(expErr));
    checkOutput("operandHold", 32'(holdBad), 32'd0);
    checkOutput("doneRstN", 32'(o_mul_rst_n), 32'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge i_clk);
      i_req_valid = 1'b1;
      i_num_x     = DW'($urandom);
      i_num_y     = DW'($urandom);
      i_res_ready = 1'b0;
      @(posedge i_clk); #1;
      checkOutput("holdValid", 32'(o_res_valid), 32'd1);
      checkOutput("holdRes", 32'(o_res), 32'(expRes));
      checkOutput("holdReady", 32'(o_req_ready), 32'd0);
    end
    @(negedge i_clk);
    i_req_valid = 1'b0;
    i_res_ready = 1'b1;
    @(posedge i_clk); #1;
    checkOutput("releaseValid", 32'(o_res_valid), 32'd0);
    checkOutput("releaseReady", 32'(o_req_ready), 32'd1);
    @(negedge i_clk);
    i_res_ready = 1'b0;
  endtask

  initial begin
    int validSeen;
    int r;
    int mode;
    i_rst       = 1'b1;
    i_req_valid = 1'b0;
    i_res_ready = 1'b0;
    i_num_x     = '0;
    i_num_y     = '0;

    // Reset values
    repeat (3) @(posedge i_clk);
    #1;
    checkOutput("rstReady", 32'(o_req_ready), 32'd0);
    checkOutput("rstMulRstN", 32'(o_mul_rst_n), 32'd0);
    checkOutput("rstNumX", 32'(o_mul_num_x), 32'd0);
    checkOutput("rstNumY", 32'(o_mul_num_y), 32'd0);
    checkOutput("rstValid", 32'(o_res_valid), 32'd0);
    checkOutput("rstRes", 32'(o_res), 32'd0);
    checkOutput("rstErr", 32'(o_res_err), 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    checkOutput("idleReady", 32'(o_req_ready), 32'd1);

    // Directed cases: basic, stalled DONE, back-to-back, watchdog, boundaries
    applyStimulus(4'b1010, 4'b1001, MODE_NORMAL, 4, 3);
    applyStimulus(4'b1010, 4'b0101, MODE_NORMAL, 4, 0);
    applyStimulus(4'b1010, 4'b1001, MODE_NORMAL, 5, 0);
    applyStimulus(4'b0110, 4'b0111, MODE_HANG, 0, 1);
    applyStimulus(4'b1111, 4'b1111, MODE_NORMAL, TO - 1, 0);
    applyStimulus(4'b0111, 4'b0011, MODE_STALE, 3, 0);
    applyStimulus(4'b1111, 4'b1110, MODE_NORMAL, 1, 0);

    // Reset in the middle of RUN discards the operation
    mulMode = MODE_NORMAL;
    mulLat  = 6;
    @(negedge i_clk);
    i_req_valid = 1'b1;
    i_num_x     = 4'b1010;
    i_num_y     = 4'b1001;
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    checkOutput("midRstValid", 32'(o_res_valid), 32'd0);
    checkOutput("midRstMulRstN", 32'(o_mul_rst_n), 32'd0);
    checkOutput("midRstRes", 32'(o_res), 32'd0);
    checkOutput("midRstErr", 32'(o_res_err), 32'd0);
    checkOutput("midRstNumX", 32'(o_mul_num_x), 32'd0);
    checkOutput("midRstReady", 32'(o_req_ready), 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    validSeen = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge i_clk); #1;
      if (o_res_valid) validSeen++;
    end
    checkOutput("noAbortResult", 32'(validSeen), 32'd0);
    checkOutput("postRstReady", 32'(o_req_ready), 32'd1);
    applyStimulus(4'b1010, 4'b1001, MODE_NORMAL, 4, 0);

    // Randomized operations
    repeat (25) begin
      r    = $urandom_range(0, 9);
      mode = (r < 6) ? MODE_NORMAL : ((r < 8) ? MODE_STALE : MODE_HANG);
      applyStimulus(DW'($urandom), DW'($urandom), mode,
                    $urandom_range(1, TO - 1), $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL globalTimeout: observed running expected finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
